link_frame_tester: RTL and testbench

Parametrised serial frame generator and loopback checker for bench-testing interleaver links on the board. It emits CHANNELS parallel PRBS bit streams in framed bursts (short or long block length, with a start strobe and a length flag) and checks the same framing format arriving on the return path. It counts mismatched bits and completed frames, and reports lock status for LEDs and the logic analyser. It supersedes the fixed single-length, two-stream hardware test harness.

---
 rtl/link_frame_tester.sv | 175 +++++++++++++++++
 tb/tb_link_frame_tester.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/link_frame_tester.sv
// link_frame_tester: framed multi-lane PRBS generator with an independent loopback checker
// that counts bit errors and completed frames for link bring-up.
module link_frame_tester #(
    parameter int CHANNELS  = 2,
    parameter int SHORT_LEN = 40,
    parameter int LONG_LEN  = 6144,
    parameter int LFSR_W    = 15,
    parameter int GAP       = 8,
    parameter int ERR_W     = 16
) (
    input  logic                clock,
    input  logic                notreset,
    input  logic                enable,
    input  logic                flag_long_sel,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                clear_counts,
    output logic [CHANNELS-1:0] data_out,
    output logic                flag_long_out,
    output logic                look_now_out,
    output logic                frame_active_out,
    input  logic [CHANNELS-1:0] data_in,
    input  logic                flag_long_in,
    input  logic                look_now_in,
    output logic [ERR_W-1:0]    err_count,
    output logic [15:0]         frames_checked,
    output logic                sync_lock,
    output logic [7:0]          byte_stream
);
    localparam int CW = $clog2(LONG_LEN);
    localparam int GW = $clog2(GAP + 1);
    localparam int NW = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FRAME = 2'd1, S_GAP = 2'd2} tx_state_t;

    function automatic logic [LFSR_W-1:0] prbs_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_W-2]};
    endfunction

    logic [LFSR_W-1:0] seed_eff;
    assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;

    tx_state_t         state, state_n;
    logic [LFSR_W-1:0] q, q_n;
    logic [CW-1:0]     cnt, cnt_n, tx_last;
    logic [GW-1:0]     gcnt, gcnt_n;
    logic              tx_long, long_n, start;
    logic [CHANNELS-1:0] tx_lanes;

    assign tx_last = tx_long ? CW'(LONG_LEN - 1) : CW'(SHORT_LEN - 1);

    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        long_n  = tx_long;
        start   = 1'b0;
        case (state)
            S_IDLE:  start = enable;
            S_FRAME: begin
                if (cnt == tx_last) begin
                    state_n = S_GAP;
                    gcnt_n  = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                    q_n   = prbs_step(q);
                end
            end
            S_GAP: begin
                if (gcnt == GW'(GAP - 1)) begin
                    state_n = S_IDLE;
                    start   = enable;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A new frame always reseeds and resamples the length select.
        if (start) begin
            state_n = S_FRAME;
            q_n     = seed_eff;
            cnt_n   = '0;
            long_n  = flag_long_sel;
        end
        for (int c = 0; c < CHANNELS; c++) tx_lanes[c] = q_n[LFSR_W-1-c];
    end

    always_ff @(posedge clock or negedge notreset) begin
        if (!notreset) begin
            state            <= S_IDLE;
            q                <= '0;
            cnt              <= '0;
            gcnt             <= '0;
            tx_long          <= 1'b0;
            data_out         <= '0;
            flag_long_out    <= 1'b0;
            look_now_out     <= 1'b0;
            frame_active_out <= 1'b0;
        end else begin
            state            <= state_n;
            q                <= q_n;
            cnt              <= cnt_n;
            gcnt             <= gcnt_n;
            tx_long          <= long_n;
            data_out         <= (state_n == S_FRAME) ? tx_lanes : '0;
            flag_long_out    <= (state_n == S_FRAME) && long_n;
            look_now_out     <= (state_n == S_FRAME) && (cnt_n == '0);
            frame_active_out <= (state_n == S_FRAME);
        end
    end

    logic [LFSR_W-1:0]   rx_q, rx_ref;
    logic [CW-1:0]       rx_cnt, rx_cnt_cur;
    logic                rx_active, rx_long, rx_ferr, rx_long_cur, rx_valid, rx_last, ferr_cur;
    logic                err_sat;
    logic [CHANNELS-1:0] mism;
    logic [NW-1:0]       nerr;
    logic [ERR_W:0]      err_sum;
    logic [ERR_W-1:0]    err_next;

    // A start strobe overrides any frame in progress, so it restarts from the seed.
    always_comb begin
        rx_ref      = look_now_in ? seed_eff : rx_q;
        rx_long_cur = look_now_in ? flag_long_in : rx_long;
        rx_cnt_cur  = look_now_in ? '0 : rx_cnt;
        rx_valid    = look_now_in | rx_active;
        nerr        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mism[c] = data_in[c] ^ rx_ref[LFSR_W-1-c];
            nerr    = nerr + NW'(mism[c]);
        end
        rx_last  = rx_valid && (rx_cnt_cur == (rx_long_cur ? CW'(LONG_LEN - 1) : CW'(SHORT_LEN - 1)));
        ferr_cur = (!look_now_in && rx_ferr) || (nerr != '0);
        err_sum  = {1'b0, err_count} + (ERR_W + 1)'(nerr);
        err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clock or negedge notreset) begin
        if (!notreset) begin
            rx_q           <= '0;
            rx_cnt         <= '0;
            rx_active      <= 1'b0;
            rx_long        <= 1'b0;
            rx_ferr        <= 1'b0;
            err_count      <= '0;
            err_sat        <= 1'b0;
            frames_checked <= '0;
            sync_lock      <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_q      <= prbs_step(rx_ref);
                rx_cnt    <= rx_cnt_cur + CW'(1);
                rx_long   <= rx_long_cur;
                rx_ferr   <= ferr_cur;
                rx_active <= !rx_last;
            end
            if (clear_counts) begin
                err_count      <= '0;
                err_sat        <= 1'b0;
                frames_checked <= '0;
                sync_lock      <= 1'b0;
            end else if (rx_valid) begin
                err_count <= err_next;
                if (err_next == '1) err_sat <= 1'b1;
                if (rx_last) begin
                    frames_checked <= frames_checked + 16'(frames_checked != 16'hFFFF);
                    sync_lock      <= !ferr_cur;
                end
            end
        end
    end

    assign byte_stream = {sync_lock, err_sat, state, err_count[3:0]};
endmodule

// File: tb/tb_link_frame_tester.sv
// tb_link_frame_tester: directed loopback bench for link_frame_tester, plus a narrow-counter
// instance fed inverted data to exercise error saturation and counter clearing.
module tb_link_frame_tester;
    logic clk = 1'b0, notreset = 1'b0;
    logic enable = 1'b0, sel = 1'b0, clr = 1'b0;
    logic [14:0] seed = 15'h1;
    logic [1:0]  data_out, data_in, inject = 2'b00;
    logic        flag_long_out, look_now_out, frame_active_out, sync_lock;
    logic [15:0] err_count, frames_checked;
    logic [7:0]  byte_stream;

    logic en_s = 1'b0, clr_s = 1'b0;
    logic [1:0]  data_out_s, data_in_s;
    logic        flag_long_s, look_now_s, frame_active_s, sync_lock_s;
    logic [3:0]  err_count_s;
    logic [15:0] frames_checked_s;
    logic [7:0]  byte_stream_s;

    int checks = 0, errors = 0;
    logic [1:0] exp_bits [16];

    always #5 clk = ~clk;

    assign data_in   = data_out ^ inject;
    assign data_in_s = ~data_out_s;

    link_frame_tester u_dut (
        .clock(clk), .notreset(notreset), .enable(enable), .flag_long_sel(sel), .seed(seed),
        .clear_counts(clr), .data_out(data_out), .flag_long_out(flag_long_out),
        .look_now_out(look_now_out), .frame_active_out(frame_active_out), .data_in(data_in),
        .flag_long_in(flag_long_out), .look_now_in(look_now_out), .err_count(err_count),
        .frames_checked(frames_checked), .sync_lock(sync_lock), .byte_stream(byte_stream)
    );

    link_frame_tester #(.ERR_W(4)) u_sat (
        .clock(clk), .notreset(notreset), .enable(en_s), .flag_long_sel(1'b0), .seed(15'h1),
        .clear_counts(clr_s), .data_out(data_out_s), .flag_long_out(flag_long_s),
        .look_now_out(look_now_s), .frame_active_out(frame_active_s), .data_in(data_in_s),
        .flag_long_in(flag_long_s), .look_now_in(look_now_s), .err_count(err_count_s),
        .frames_checked(frames_checked_s), .sync_lock(sync_lock_s), .byte_stream(byte_stream_s)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL reset data_out got %0h want 0", data_out); end
        checks++; if (look_now_out !== 1'b0) begin errors++; $display("FAIL reset look_now got %0b want 0", look_now_out); end
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL reset frame_active got %0b want 0", frame_active_out); end
        checks++; if (flag_long_out !== 1'b0) begin errors++; $display("FAIL reset flag_long got %0b want 0", flag_long_out); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset err_count got %0d want 0", err_count); end
        checks++; if (frames_checked !== 16'd0) begin errors++; $display("FAIL reset frames got %0d want 0", frames_checked); end
        checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL reset sync_lock got %0b want 0", sync_lock); end
        checks++; if (byte_stream !== 8'h00) begin errors++; $display("FAIL reset byte_stream got %0h want 0", byte_stream); end
        notreset = 1'b1;
        step(2);
        checks++; if (look_now_out !== 1'b0) begin errors++; $display("FAIL idle look_now got %0b want 0", look_now_out); end
    endtask

    task automatic check_frame_bits(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step(1);
            checks++; if (data_out !== exp_bits[i]) begin errors++; $display("FAIL %s bit %0d data_out got %0b want %0b", tag, i, data_out, exp_bits[i]); end
        end
    endtask

    task automatic test_loopback;
        seed = 15'h1; enable = 1'b1;
        step(1);
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL f1 look_now got %0b want 1", look_now_out); end
        checks++; if (frame_active_out !== 1'b1) begin errors++; $display("FAIL f1 frame_active got %0b want 1", frame_active_out); end
        checks++; if (byte_stream[5:4] !== 2'd1) begin errors++; $display("FAIL f1 tx_state got %0d want 1", byte_stream[5:4]); end
        check_frame_bits("seed1");
        checks++; if (look_now_out !== 1'b0) begin errors++; $display("FAIL f1 bit15 look_now got %0b want 0", look_now_out); end
        step(24);
        checks++; if (frame_active_out !== 1'b1) begin errors++; $display("FAIL f1 last frame_active got %0b want 1", frame_active_out); end
        checks++; if (frames_checked !== 16'd0) begin errors++; $display("FAIL f1 early frames got %0d want 0", frames_checked); end
        step(1);
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL f1 gap frame_active got %0b want 0", frame_active_out); end
        checks++; if (frames_checked !== 16'd1) begin errors++; $display("FAIL f1 frames got %0d want 1", frames_checked); end
        checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL f1 sync_lock got %0b want 1", sync_lock); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL f1 err_count got %0d want 0", err_count); end
        checks++; if (byte_stream[5:4] !== 2'd2) begin errors++; $display("FAIL f1 gap tx_state got %0d want 2", byte_stream[5:4]); end
        step(7);
        checks++; if (look_now_out !== 1'b0) begin errors++; $display("FAIL gap end look_now got %0b want 0", look_now_out); end
        step(1);
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL f2 period look_now got %0b want 1", look_now_out); end
        step(5);
        inject = 2'b10;
        step(1);
        inject = 2'b00;
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL f2 err_count got %0d want 1", err_count); end
        step(34);
        checks++; if (frames_checked !== 16'd2) begin errors++; $display("FAIL f2 frames got %0d want 2", frames_checked); end
        checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL f2 sync_lock got %0b want 0", sync_lock); end
        step(48);
        checks++; if (frames_checked !== 16'd3) begin errors++; $display("FAIL f3 frames got %0d want 3", frames_checked); end
        checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL f3 sync_lock got %0b want 1", sync_lock); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL f3 err_count got %0d want 1", err_count); end
    endtask

    task automatic test_seed_zero;
        seed = 15'h0;
        step(8);
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL f4 look_now got %0b want 1", look_now_out); end
        check_frame_bits("seed0");
        step(25);
        checks++; if (frames_checked !== 16'd4) begin errors++; $display("FAIL f4 frames got %0d want 4", frames_checked); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL f4 err_count got %0d want 1", err_count); end
        checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL f4 sync_lock got %0b want 1", sync_lock); end
    endtask

    task automatic test_enable_drop;
        int seen;
        step(8);
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL f5 look_now got %0b want 1", look_now_out); end
        step(10);
        enable = 1'b0;
        step(29);
        checks++; if (frame_active_out !== 1'b1) begin errors++; $display("FAIL f5 last frame_active got %0b want 1", frame_active_out); end
        step(1);
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL f5 gap frame_active got %0b want 0", frame_active_out); end
        checks++; if (frames_checked !== 16'd5) begin errors++; $display("FAIL f5 frames got %0d want 5", frames_checked); end
        step(7);
        checks++; if (byte_stream[5:4] !== 2'd2) begin errors++; $display("FAIL f5 gap tx_state got %0d want 2", byte_stream[5:4]); end
        step(1);
        checks++; if (byte_stream[5:4] !== 2'd0) begin errors++; $display("FAIL f5 idle tx_state got %0d want 0", byte_stream[5:4]); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (look_now_out || frame_active_out) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL idle activity got %0d want 0", seen); end
    endtask

    task automatic test_long;
        sel = 1'b1; enable = 1'b1;
        step(1);
        enable = 1'b0; sel = 1'b0;
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL long look_now got %0b want 1", look_now_out); end
        checks++; if (flag_long_out !== 1'b1) begin errors++; $display("FAIL long flag bit0 got %0b want 1", flag_long_out); end
        step(3000);
        checks++; if (flag_long_out !== 1'b1) begin errors++; $display("FAIL long flag mid got %0b want 1", flag_long_out); end
        step(3143);
        checks++; if (frame_active_out !== 1'b1) begin errors++; $display("FAIL long last frame_active got %0b want 1", frame_active_out); end
        checks++; if (flag_long_out !== 1'b1) begin errors++; $display("FAIL long flag last got %0b want 1", flag_long_out); end
        checks++; if (frames_checked !== 16'd5) begin errors++; $display("FAIL long early frames got %0d want 5", frames_checked); end
        step(1);
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL long end frame_active got %0b want 0", frame_active_out); end
        checks++; if (frames_checked !== 16'd6) begin errors++; $display("FAIL long frames got %0d want 6", frames_checked); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL long err_count got %0d want 1", err_count); end
        checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL long sync_lock got %0b want 1", sync_lock); end
        step(10);
    endtask

    task automatic test_saturate;
        en_s = 1'b1;
        step(1);
        en_s = 1'b0;
        checks++; if (look_now_s !== 1'b1) begin errors++; $display("FAIL sat look_now got %0b want 1", look_now_s); end
        step(3);
        checks++; if (err_count_s !== 4'd6) begin errors++; $display("FAIL sat partial err got %0d want 6", err_count_s); end
        checks++; if (byte_stream_s[6] !== 1'b0) begin errors++; $display("FAIL sat early err_sat got %0b want 0", byte_stream_s[6]); end
        step(36);
        checks++; if (err_count_s !== 4'd15) begin errors++; $display("FAIL sat err_count got %0d want 15", err_count_s); end
        checks++; if (byte_stream_s[6] !== 1'b1) begin errors++; $display("FAIL sat err_sat got %0b want 1", byte_stream_s[6]); end
        step(1);
        checks++; if (frames_checked_s !== 16'd1) begin errors++; $display("FAIL sat frames got %0d want 1", frames_checked_s); end
        checks++; if (sync_lock_s !== 1'b0) begin errors++; $display("FAIL sat sync_lock got %0b want 0", sync_lock_s); end
        checks++; if (byte_stream_s[3:0] !== 4'hF) begin errors++; $display("FAIL sat byte_stream low got %0h want f", byte_stream_s[3:0]); end
        step(10);
        clr_s = 1'b1;
        step(1);
        clr_s = 1'b0;
        checks++; if (err_count_s !== 4'd0) begin errors++; $display("FAIL clear err_count got %0d want 0", err_count_s); end
        checks++; if (frames_checked_s !== 16'd0) begin errors++; $display("FAIL clear frames got %0d want 0", frames_checked_s); end
        checks++; if (byte_stream_s[6] !== 1'b0) begin errors++; $display("FAIL clear err_sat got %0b want 0", byte_stream_s[6]); end
    endtask

    task automatic test_reset_mid;
        enable = 1'b1;
        step(1);
        checks++; if (look_now_out !== 1'b1) begin errors++; $display("FAIL rm look_now got %0b want 1", look_now_out); end
        step(10);
        notreset = 1'b0;
        #1;
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL rm frame_active got %0b want 0", frame_active_out); end
        checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL rm data_out got %0h want 0", data_out); end
        checks++; if (frames_checked !== 16'd0) begin errors++; $display("FAIL rm frames got %0d want 0", frames_checked); end
        checks++; if (byte_stream !== 8'h00) begin errors++; $display("FAIL rm byte_stream got %0h want 0", byte_stream); end
        enable = 1'b0;
        step(1);
        notreset = 1'b1;
        step(60);
        checks++; if (frames_checked !== 16'd0) begin errors++; $display("FAIL rm after frames got %0d want 0", frames_checked); end
        checks++; if (frame_active_out !== 1'b0) begin errors++; $display("FAIL rm after frame_active got %0b want 0", frame_active_out); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) exp_bits[i] = 2'b00;
        exp_bits[13] = 2'b10;
        exp_bits[14] = 2'b01;
        test_reset;
        test_loopback;
        test_seed_zero;
        test_enable_drop;
        test_long;
        test_saturate;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
